seg7_scan_decoder: RTL and testbench
====================================

Name: seg7_scan_decoder

Overview:
- Reads a time-multiplexed 7-segment display bus (segment lines plus one-hot digit enables) and recovers the hex digits being shown.
- It is the receive-side counterpart of the team's hex-to-7-segment encoder.
- Used as a display monitor: self-check of display drivers on board, and loopback in benches.
- Produces a full multi-digit value plus per-digit error flags once every digit has been seen in a scan frame.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (an width); value width is 4*NUM_DIGITS.
- STABLE_CYCLES, 8, consecutive identical registered samples of (an, seg) required before a digit is captured; legal range 2..255.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- seg  input  7  segment lines, active-high, bit0=a … bit5=f, bit6=g; same clock domain as clk.
- an  input  NUM_DIGITS  digit enables, active-high; one-hot while a digit is driven.
- value  output  4*NUM_DIGITS  last complete frame; digit i in bits [4i+3:4i].
- digit_err  output  NUM_DIGITS  bit i set if digit i of the last frame was an unrecognised pattern.
- frame_valid  output  1  one-cycle pulse when value/digit_err update.
- scan_err  output  1  sticky; set when an has more than one bit high; cleared only by reset.

Behaviour:
- Reset (async, rst_n=0): value=0, digit_err=0, frame_valid=0, scan_err=0. Internal state is cleared: sample registers, stable counter, seen mask, shadow nibbles, FSM=IDLE.
- Input stage: seg and an are registered once (s_seg, s_an) every cycle. All decisions use the registered copies.
- Stable counter cnt (width ceil(log2(STABLE_CYCLES+1))):
  - Reset to 1 when (s_an, s_seg) differs from the previous registered sample, or when s_an is not one-hot.
  - Otherwise increments, saturating at STABLE_CYCLES.
- FSM:
  - IDLE: s_an is zero or not one-hot. No capture. Go to SETTLE when s_an becomes one-hot.
  - SETTLE: s_an is one-hot and cnt < STABLE_CYCLES. On the edge where cnt reaches STABLE_CYCLES, capture and go to HELD.
  - HELD: digit already captured; no further capture. Any change in s_an or s_seg returns to SETTLE (if one-hot) or IDLE (if not).
- Capture of digit i:
  - The decoder maps s_seg to a nibble. 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
  - If the pattern matches: shadow[i] = nibble and err_sh[i] = 0.
  - If it does not match (including 00): shadow[i] = 0 and err_sh[i] = 1.
  - Set seen[i]. Recapturing an already-seen digit in the same frame overwrites its shadow entry.
- Frame completion:
  - On the same edge as a capture that makes seen all-ones: value <= shadow including the new nibble, digit_err <= err_sh including the new bit, frame_valid = 1 for that single cycle, seen <= 0.
  - value and digit_err hold between frames.
- Latency: a digit pattern must be present at the pins for STABLE_CYCLES cycles. Capture happens STABLE_CYCLES cycles after the first pin-level cycle of a dwell (1 register cycle + STABLE_CYCLES-1 count cycles).
- Boundary conditions:
  - Dwell shorter than STABLE_CYCLES: no capture for that digit.
  - Blanking gap (an=0) between digits: allowed, no effect on seen.
  - Multiple an bits high: treated as IDLE, no capture, scan_err set.
  - Same digit re-enabled with a new pattern: counted as a fresh dwell and recaptured.
  - Reset mid-frame: partial seen mask and shadow are discarded.

Decomposition:
- Package seg7_pkg: the 16 segment-pattern constants (shared with the encoder), segment bit-index constants, and the default NUM_DIGITS.
- Sub-module seg7_pattern_decode: purely combinational, seg[6:0] -> {hit, nibble[3:0]}. It is the exact inverse of the encoder table and is reusable in benches.

Test Plan:
- Scan digits 0..3 with patterns 06,5B,4F,66, each for 10 cycles, an one-hot -> frame_valid pulses once, value=16'h4321, digit_err=0.
- Same scan, but digit 2 held for only 5 cycles -> no frame_valid; on the next full scan, value=16'h4321 with one pulse.
- Digit 1 pattern 7'h00 in an otherwise valid scan of F,E,d,C (71,79,5E,39) -> value=16'hCD0F, digit_err=4'b0010.
- an=4'b0011 for 20 cycles mid-scan -> scan_err=1 and stays 1; the remaining valid digits still complete the frame.
- Exhaustive: each of the 16 patterns on all digits -> each nibble decodes correctly; each of the 112 non-table patterns -> digit_err set.
- Assert rst_n low after 2 of 4 digits are captured, then rescan 9,A,b,8 -> value=16'h8BA9; no stale digits; outputs are 0 while in reset.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment bit positions, hex glyph table,
// and the scan receiver state type.
package seg7_pkg;

    localparam int DEFAULT_DIGITS = 4;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A_HEX = 7'h77;
    localparam logic [6:0] SEG_B_HEX = 7'h7C;
    localparam logic [6:0] SEG_C_HEX = 7'h39;
    localparam logic [6:0] SEG_D_HEX = 7'h5E;
    localparam logic [6:0] SEG_E_HEX = 7'h79;
    localparam logic [6:0] SEG_F_HEX = 7'h71;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_HELD
    } scan_st_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the hex-to-7-segment encoder table.
// hit is low for any pattern that is not one of the 16 glyphs.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic       hit,
    output logic [3:0] nibble
);

    always_comb begin
        hit    = 1'b1;
        nibble = 4'h0;
        unique case (seg)
            SEG_0:     nibble = 4'h0;
            SEG_1:     nibble = 4'h1;
            SEG_2:     nibble = 4'h2;
            SEG_3:     nibble = 4'h3;
            SEG_4:     nibble = 4'h4;
            SEG_5:     nibble = 4'h5;
            SEG_6:     nibble = 4'h6;
            SEG_7:     nibble = 4'h7;
            SEG_8:     nibble = 4'h8;
            SEG_9:     nibble = 4'h9;
            SEG_A_HEX: nibble = 4'hA;
            SEG_B_HEX: nibble = 4'hB;
            SEG_C_HEX: nibble = 4'hC;
            SEG_D_HEX: nibble = 4'hD;
            SEG_E_HEX: nibble = 4'hE;
            SEG_F_HEX: nibble = 4'hF;
            default:   hit    = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Monitors a multiplexed 7-segment bus and rebuilds the displayed
// hex value once every digit has been captured in a scan frame.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = DEFAULT_DIGITS,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   an,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    frame_valid,
    output logic                    scan_err
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int VW = 4 * NUM_DIGITS;
    localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);

    logic [6:0]            s_seg, p_seg;
    logic [NUM_DIGITS-1:0] s_an, p_an;
    logic [CW-1:0]         cnt, cnt_nxt;
    scan_st_e              state, state_nxt;
    logic [NUM_DIGITS-1:0] seen, seen_nxt;
    logic [NUM_DIGITS-1:0] err_sh, err_nxt;
    logic [VW-1:0]         shadow, shadow_nxt;
    logic                  onehot, chg, cap, done;
    logic                  hit;
    logic [3:0]            nib;

    seg7_pattern_decode u_dec (
        .seg    (s_seg),
        .hit    (hit),
        .nibble (nib)
    );

    assign onehot = $onehot(s_an);
    assign chg    = (s_an != p_an) || (s_seg != p_seg);

    always_comb begin
        if (chg || !onehot)
            cnt_nxt = CW'(1);
        else if (cnt == CMAX)
            cnt_nxt = cnt;
        else
            cnt_nxt = cnt + CW'(1);
    end

    always_comb begin
        state_nxt = state;
        cap       = 1'b0;
        if (!onehot) begin
            state_nxt = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE:   state_nxt = ST_SETTLE;
                ST_SETTLE: begin
                    if (!chg && cnt_nxt == CMAX) begin
                        cap       = 1'b1;
                        state_nxt = ST_HELD;
                    end
                end
                ST_HELD:   if (chg) state_nxt = ST_SETTLE;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    // s_an is one-hot whenever cap is high, so exactly one slot updates
    always_comb begin
        shadow_nxt = shadow;
        err_nxt    = err_sh;
        seen_nxt   = seen;
        if (cap) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (s_an[i]) begin
                    shadow_nxt[4*i +: 4] = hit ? nib : 4'h0;
                    err_nxt[i]           = ~hit;
                    seen_nxt[i]          = 1'b1;
                end
            end
        end
        done = cap && (&seen_nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_seg       <= '0;
            s_an        <= '0;
            p_seg       <= '0;
            p_an        <= '0;
            cnt         <= '0;
            state       <= ST_IDLE;
            shadow      <= '0;
            err_sh      <= '0;
            seen        <= '0;
            value       <= '0;
            digit_err   <= '0;
            frame_valid <= 1'b0;
            scan_err    <= 1'b0;
        end else begin
            s_seg       <= seg;
            s_an        <= an;
            p_seg       <= s_seg;
            p_an        <= s_an;
            cnt         <= cnt_nxt;
            state       <= state_nxt;
            shadow      <= shadow_nxt;
            err_sh      <= err_nxt;
            seen        <= done ? '0 : seen_nxt;
            frame_valid <= done;
            if (done) begin
                value     <= shadow_nxt;
                digit_err <= err_nxt;
            end
            if ((|s_an) && !onehot)
                scan_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: scans digits onto the bus and
// checks recovered value, error flags and frame pulses.
module tb_seg7_scan_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg = '0;
    logic [3:0]  an = '0;
    logic [15:0] value;
    logic [3:0]  digit_err;
    logic        frame_valid;
    logic        scan_err;

    int checks = 0;
    int errors = 0;
    int fv_cnt = 0;

    logic [6:0] tbl [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    seg7_scan_decoder #(
        .NUM_DIGITS    (4),
        .STABLE_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg         (seg),
        .an          (an),
        .value       (value),
        .digit_err   (digit_err),
        .frame_valid (frame_valid),
        .scan_err    (scan_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (frame_valid === 1'b1) fv_cnt++;

    task automatic show(input int d, input logic [6:0] p, input int n);
        an  = 4'(1 << d);
        seg = p;
        repeat (n) @(negedge clk);
    endtask

    task automatic blank(input int n);
        an  = '0;
        seg = '0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        an    = '0;
        seg   = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if (value !== 16'h0) begin
            errors++;
            $display("FAIL reset_value: got %h expected 0000", value);
        end
        checks++;
        if (digit_err !== 4'h0) begin
            errors++;
            $display("FAIL reset_err: got %b expected 0000", digit_err);
        end
        checks++;
        if (frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_fv: got %b expected 0", frame_valid);
        end
        checks++;
        if (scan_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_scan_err: got %b expected 0", scan_err);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int f0;
        do_reset();
        f0 = fv_cnt;
        show(0, 7'h06, 10); blank(2);
        show(1, 7'h5B, 10); blank(2);
        show(2, 7'h4F, 10); blank(2);
        show(3, 7'h66, 10); blank(2);
        #1;
        checks++;
        if (fv_cnt - f0 != 1) begin
            errors++;
            $display("FAIL basic_pulses: got %0d expected 1", fv_cnt - f0);
        end
        checks++;
        if (value !== 16'h4321) begin
            errors++;
            $display("FAIL basic_value: got %h expected 4321", value);
        end
        checks++;
        if (digit_err !== 4'h0) begin
            errors++;
            $display("FAIL basic_err: got %b expected 0000", digit_err);
        end
    endtask

    task automatic test_short_dwell;
        int f0;
        do_reset();
        f0 = fv_cnt;
        show(0, 7'h06, 10);
        show(1, 7'h5B, 10);
        show(2, 7'h4F, 5);
        show(3, 7'h66, 10);
        blank(2); #1;
        checks++;
        if (fv_cnt != f0 || value !== 16'h0) begin
            errors++;
            $display("FAIL short5_nocap: got pulses %0d value %h expected 0 0000",
                     fv_cnt - f0, value);
        end
        f0 = fv_cnt;
        show(0, 7'h06, 10);
        show(1, 7'h5B, 10);
        show(2, 7'h4F, 10);
        show(3, 7'h66, 10);
        blank(2); #1;
        checks++;
        if (fv_cnt - f0 != 1 || value !== 16'h4321) begin
            errors++;
            $display("FAIL short5_rescan: got pulses %0d value %h expected 1 4321",
                     fv_cnt - f0, value);
        end
        do_reset();
        f0 = fv_cnt;
        show(0, 7'h3F, 8);
        show(1, 7'h06, 8);
        show(2, 7'h5B, 7);
        show(3, 7'h4F, 8);
        blank(2); #1;
        checks++;
        if (fv_cnt != f0) begin
            errors++;
            $display("FAIL dwell7_nocap: got pulses %0d expected 0", fv_cnt - f0);
        end
        do_reset();
        f0 = fv_cnt;
        show(0, 7'h3F, 8);
        show(1, 7'h06, 8);
        show(2, 7'h5B, 8);
        show(3, 7'h4F, 8);
        blank(2); #1;
        checks++;
        if (fv_cnt - f0 != 1 || value !== 16'h3210) begin
            errors++;
            $display("FAIL dwell8_cap: got pulses %0d value %h expected 1 3210",
                     fv_cnt - f0, value);
        end
    endtask

    task automatic test_err_digit;
        int f0;
        do_reset();
        f0 = fv_cnt;
        show(0, 7'h71, 10); blank(1);
        show(1, 7'h00, 10); blank(1);
        show(2, 7'h5E, 10); blank(1);
        show(3, 7'h39, 10); blank(2);
        #1;
        checks++;
        if (fv_cnt - f0 != 1 || value !== 16'hCD0F) begin
            errors++;
            $display("FAIL errdig_value: got pulses %0d value %h expected 1 cd0f",
                     fv_cnt - f0, value);
        end
        checks++;
        if (digit_err !== 4'b0010) begin
            errors++;
            $display("FAIL errdig_flags: got %b expected 0010", digit_err);
        end
    endtask

    task automatic test_scan_err;
        int f0;
        do_reset();
        f0 = fv_cnt;
        show(0, 7'h06, 10);
        show(1, 7'h5B, 10);
        blank(1); #1;
        checks++;
        if (scan_err !== 1'b0) begin
            errors++;
            $display("FAIL scanerr_pre: got %b expected 0", scan_err);
        end
        an  = 4'b0011;
        seg = 7'h4F;
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (scan_err !== 1'b1 || fv_cnt != f0) begin
            errors++;
            $display("FAIL scanerr_set: got %b pulses %0d expected 1 0",
                     scan_err, fv_cnt - f0);
        end
        show(2, 7'h4F, 10);
        show(3, 7'h66, 10);
        blank(3); #1;
        checks++;
        if (fv_cnt - f0 != 1 || value !== 16'h4321) begin
            errors++;
            $display("FAIL scanerr_frame: got pulses %0d value %h expected 1 4321",
                     fv_cnt - f0, value);
        end
        checks++;
        if (scan_err !== 1'b1) begin
            errors++;
            $display("FAIL scanerr_sticky: got %b expected 1", scan_err);
        end
    endtask

    task automatic test_table;
        int f0;
        logic [15:0] exp;
        do_reset();
        for (int p = 0; p < 16; p++) begin
            f0 = fv_cnt;
            for (int d = 0; d < 4; d++) show(d, tbl[p], 9);
            blank(2); #1;
            exp = {4{4'(p)}};
            checks++;
            if (fv_cnt - f0 != 1 || value !== exp || digit_err !== 4'h0) begin
                errors++;
                $display("FAIL table_%0d: got pulses %0d value %h err %b expected 1 %h 0000",
                         p, fv_cnt - f0, value, digit_err, exp);
            end
        end
    endtask

    task automatic test_bad_patterns;
        int f0, k;
        bit in_tbl;
        logic [15:0] exp;
        logic [3:0]  exp_err;
        do_reset();
        for (int v = 0; v < 128; v++) begin
            in_tbl = 1'b0;
            for (int j = 0; j < 16; j++)
                if (tbl[j] == 7'(v)) in_tbl = 1'b1;
            if (!in_tbl) begin
                k  = v % 4;
                f0 = fv_cnt;
                for (int d = 0; d < 4; d++)
                    show(d, (d == k) ? 7'(v) : tbl[d], 9);
                blank(2); #1;
                exp          = 16'h3210;
                exp[4*k +: 4] = 4'h0;
                exp_err      = 4'(1 << k);
                checks++;
                if (fv_cnt - f0 != 1 || value !== exp || digit_err !== exp_err) begin
                    errors++;
                    $display("FAIL bad_%02h: got pulses %0d value %h err %b expected 1 %h %b",
                             v, fv_cnt - f0, value, digit_err, exp, exp_err);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        int f0;
        do_reset();
        show(0, 7'h06, 10);
        show(1, 7'h5B, 10);
        show(2, 7'h4F, 10);
        show(3, 7'h66, 10);
        show(0, 7'h07, 10);
        show(1, 7'h6D, 10);
        rst_n = 1'b0;
        #1;
        checks++;
        if (value !== 16'h0 || digit_err !== 4'h0 || frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs: got %h %b %b expected 0000 0000 0",
                     value, digit_err, frame_valid);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        f0 = fv_cnt;
        show(2, 7'h7C, 10);
        show(3, 7'h7F, 10);
        blank(2); #1;
        checks++;
        if (fv_cnt != f0) begin
            errors++;
            $display("FAIL midrst_stale: got pulses %0d expected 0", fv_cnt - f0);
        end
        show(0, 7'h6F, 10);
        show(1, 7'h77, 10);
        blank(2); #1;
        checks++;
        if (fv_cnt - f0 != 1 || value !== 16'h8BA9 || digit_err !== 4'h0) begin
            errors++;
            $display("FAIL midrst_rescan: got pulses %0d value %h err %b expected 1 8ba9 0000",
                     fv_cnt - f0, value, digit_err);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short_dwell();
        test_err_digit();
        test_scan_err();
        test_table();
        test_bad_patterns();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
